// File: rtl/clause_eval_pipe.sv
// Pipelined NUM_LIT-literal clause evaluator with replicated variable-table banks.
// Reports break status, true-literal count, critical literal and a saturating unsat count.
module clause_eval_pipe #(
  parameter int NUM_LIT = 3,
  parameter int VAR_AW  = 11,
  parameter int IDX_W   = 12,
  parameter int CNT_W   = 16,
  localparam int TC_W   = $clog2(NUM_LIT + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [NUM_LIT-1:0]         in_neg_i,
  input  logic [NUM_LIT*VAR_AW-1:0]  in_addr_i,
  input  logic [NUM_LIT*IDX_W-1:0]   in_idx_i,
  input  logic                       wr_en_i,
  input  logic [VAR_AW-1:0]          wr_addr_i,
  input  logic                       wr_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       out_brk_o,
  output logic [TC_W-1:0]            out_true_cnt_o,
  output logic [NUM_LIT-1:0]         out_crit_o,
  output logic [NUM_LIT-1:0]         out_vals_o,
  output logic [NUM_LIT*IDX_W-1:0]   out_idx_o,
  output logic [CNT_W-1:0]           unsat_cnt_o,
  input  logic                       cnt_clr_i
);

  localparam int DEPTH = 2 ** VAR_AW;

  logic                      adv;
  logic                      acc;
  logic [NUM_LIT*VAR_AW-1:0] rd_addr;

  logic                      s1_valid_q;
  logic [NUM_LIT*VAR_AW-1:0] s1_addr_q;
  logic [NUM_LIT-1:0]        s1_neg_q;
  logic [NUM_LIT*IDX_W-1:0]  s1_idx_q;
  logic [NUM_LIT-1:0]        ram_q;

  logic                      wr_en_q;
  logic [VAR_AW-1:0]         wr_addr_q;
  logic                      wr_data_q;

  logic [NUM_LIT-1:0]        vals_d;
  logic [NUM_LIT-1:0]        lits_d;
  logic [TC_W-1:0]           true_cnt_d;
  logic                      brk_d;
  logic [NUM_LIT-1:0]        crit_d;
  logic [NUM_LIT*IDX_W-1:0]  idx_d;

  logic                      out_valid_q;
  logic                      out_brk_q;
  logic [TC_W-1:0]           out_true_cnt_q;
  logic [NUM_LIT-1:0]        out_crit_q;
  logic [NUM_LIT-1:0]        out_vals_q;
  logic [NUM_LIT*IDX_W-1:0]  out_idx_q;
  logic [CNT_W-1:0]          unsat_cnt_q;
  logic [CNT_W-1:0]          unsat_cnt_d;

  assign adv        = !out_valid_q || out_ready_i;
  assign acc        = in_valid_i && adv;
  assign in_ready_o = adv;

  // While stalled the banks keep re-reading the held S1 addresses so writes stay visible.
  assign rd_addr = adv ? in_addr_i : s1_addr_q;

  for (genvar g = 0; g < NUM_LIT; g++) begin : g_bank
    logic bank_mem [DEPTH];
    logic rd_q;

    always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
        bank_mem[wr_addr_i] <= wr_data_i;
      end
      rd_q <= bank_mem[rd_addr[g*VAR_AW +: VAR_AW]];
    end

    assign ram_q[g] = rd_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
    end else begin
      wr_en_q <= wr_en_i;
      if (adv) begin
        s1_valid_q <= acc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    wr_addr_q <= wr_addr_i;
    wr_data_q <= wr_data_i;
    if (adv) begin
      s1_addr_q <= in_addr_i;
      s1_neg_q  <= in_neg_i;
      s1_idx_q  <= in_idx_i;
    end
  end

  // The live write is newest, then last cycle's write (the bank returned old data for it).
  always_comb begin
    vals_d     = '0;
    true_cnt_d = '0;
    for (int i = 0; i < NUM_LIT; i++) begin
      if (wr_en_i && (wr_addr_i == s1_addr_q[i*VAR_AW +: VAR_AW])) begin
        vals_d[i] = wr_data_i;
      end else if (wr_en_q && (wr_addr_q == s1_addr_q[i*VAR_AW +: VAR_AW])) begin
        vals_d[i] = wr_data_q;
      end else begin
        vals_d[i] = ram_q[i];
      end
    end
    lits_d = vals_d ^ s1_neg_q;
    for (int i = 0; i < NUM_LIT; i++) begin
      true_cnt_d = true_cnt_d + TC_W'(lits_d[i]);
    end
    brk_d  = (lits_d == '0);
    crit_d = (true_cnt_d == TC_W'(1)) ? lits_d : '0;
    idx_d  = brk_d ? s1_idx_q : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q    <= 1'b0;
      out_brk_q      <= 1'b0;
      out_true_cnt_q <= '0;
      out_crit_q     <= '0;
      out_vals_q     <= '0;
      out_idx_q      <= '0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_brk_q      <= brk_d;
        out_true_cnt_q <= true_cnt_d;
        out_crit_q     <= crit_d;
        out_vals_q     <= vals_d;
        out_idx_q      <= idx_d;
      end
    end
  end

  always_comb begin
    unsat_cnt_d = unsat_cnt_q;
    if (cnt_clr_i) begin
      unsat_cnt_d = '0;
    end else if (out_valid_q && out_ready_i && out_brk_q && (unsat_cnt_q != {CNT_W{1'b1}})) begin
      unsat_cnt_d = unsat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      unsat_cnt_q <= '0;
    end else begin
      unsat_cnt_q <= unsat_cnt_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_brk_o      = out_brk_q;
  assign out_true_cnt_o = out_true_cnt_q;
  assign out_crit_o     = out_crit_q;
  assign out_vals_o     = out_vals_q;
  assign out_idx_o      = out_idx_q;
  assign unsat_cnt_o    = unsat_cnt_q;

endmodule

// File: tb/tb_clause_eval_pipe.sv
// Scoreboard bench for clause_eval_pipe: directed clauses push hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_clause_eval_pipe;

  localparam int NL = 3;
  localparam int AW = 11;
  localparam int IW = 12;
  localparam int CW = 2;
  localparam int TW = 2;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NL-1:0]     in_neg;
  logic [NL*AW-1:0]  in_addr;
  logic [NL*IW-1:0]  in_idx;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic              wr_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_brk;
  logic [TW-1:0]     out_true_cnt;
  logic [NL-1:0]     out_crit;
  logic [NL-1:0]     out_vals;
  logic [NL*IW-1:0]  out_idx;
  logic [CW-1:0]     unsat_cnt;
  logic              cnt_clr;

  typedef struct {
    logic             brk;
    logic [TW-1:0]    cnt;
    logic [NL-1:0]    crit;
    logic [NL-1:0]    vals;
    logic [NL*IW-1:0] idx;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a0, a1, a2;
    logic [NL-1:0] neg;
    int            ib;
    exp_t          e;
  } vec_t;

  exp_t expQ[$];
  exp_t monE;
  int   checks = 0;
  int   errors = 0;

  clause_eval_pipe #(.NUM_LIT(NL), .VAR_AW(AW), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_neg_i(in_neg), .in_addr_i(in_addr), .in_idx_i(in_idx),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_brk_o(out_brk), .out_true_cnt_o(out_true_cnt), .out_crit_o(out_crit),
    .out_vals_o(out_vals), .out_idx_o(out_idx),
    .unsat_cnt_o(unsat_cnt), .cnt_clr_i(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result actual=%0h required=none",
                 {out_brk, out_true_cnt, out_crit, out_vals, out_idx});
      end else begin
        monE = expQ.pop_front();
        checkOutput("result", {19'd0, out_brk, out_true_cnt, out_crit, out_vals, out_idx},
                    {19'd0, monE.brk, monE.cnt, monE.crit, monE.vals, monE.idx});
      end
    end
  end

  function automatic logic [NL*IW-1:0] mkIdx(input int base);
    return {IW'(base + 2), IW'(base + 1), IW'(base)};
  endfunction

  function automatic exp_t mkExp(input logic brk, input logic [TW-1:0] cnt,
                                 input logic [NL-1:0] crit, input logic [NL-1:0] vals,
                                 input int ib);
    exp_t e;
    e.brk  = brk;
    e.cnt  = cnt;
    e.crit = crit;
    e.vals = vals;
    e.idx  = brk ? mkIdx(ib) : '0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic presentClause(input logic [AW-1:0] a0, a1, a2, input logic [NL-1:0] neg, input int ib);
    in_valid = 1'b1;
    in_addr  = {a2, a1, a0};
    in_neg   = neg;
    in_idx   = mkIdx(ib);
  endtask

  task automatic writeVar(input logic [AW-1:0] a, input logic d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] a0, a1, a2, input logic [NL-1:0] neg,
                               input int ib, input exp_t e);
    int n;
    presentClause(a0, a1, a2, neg, ib);
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      #1;
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    expQ.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    if (expQ.size() > 0) begin
      checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
      expQ.delete();
    end
  endtask

  vec_t streamV[3];

  initial begin
    int k, cyc, n;
    logic accepted;
    rst = 1'b1; in_valid = 1'b0; in_neg = '0; in_addr = '0; in_idx = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    tick();
    tick();
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_brk", 64'(out_brk), 64'd0);
    checkOutput("rst_true_cnt", 64'(out_true_cnt), 64'd0);
    checkOutput("rst_crit", 64'(out_crit), 64'd0);
    checkOutput("rst_vals", 64'(out_vals), 64'd0);
    checkOutput("rst_idx", 64'(out_idx), 64'd0);
    checkOutput("rst_unsat_cnt", 64'(unsat_cnt), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    writeVar(11'd5, 1'b0);
    writeVar(11'd9, 1'b0);
    writeVar(11'd12, 1'b0);
    writeVar(11'd20, 1'b1);
    writeVar(11'd21, 1'b0);
    writeVar(11'd22, 1'b1);

    // all-false clause breaks and echoes its index tags
    applyStimulus(11'd5, 11'd9, 11'd12, 3'b000, 100, mkExp(1'b1, 2'd0, 3'b000, 3'b000, 100));
    drain();
    applyStimulus(11'd5, 11'd9, 11'd12, 3'b010, 110, mkExp(1'b0, 2'd1, 3'b010, 3'b000, 110));
    applyStimulus(11'd20, 11'd21, 11'd22, 3'b000, 120, mkExp(1'b0, 2'd2, 3'b000, 3'b101, 120));
    applyStimulus(11'd20, 11'd21, 11'd22, 3'b111, 130, mkExp(1'b0, 2'd1, 3'b010, 3'b101, 130));
    applyStimulus(11'd20, 11'd22, 11'd20, 3'b000, 140, mkExp(1'b0, 2'd3, 3'b000, 3'b111, 140));
    applyStimulus(11'd21, 11'd21, 11'd5, 3'b011, 150, mkExp(1'b0, 2'd2, 3'b000, 3'b000, 150));
    drain();

    // write to var 9 on the accept edge: bank returns old data, S1 must forward
    presentClause(11'd5, 11'd9, 11'd12, 3'b000, 200);
    wr_en = 1'b1; wr_addr = 11'd9; wr_data = 1'b1;
    #1;
    checkOutput("fwd_edge_in_ready", 64'(in_ready), 64'd1);
    expQ.push_back(mkExp(1'b0, 2'd1, 3'b010, 3'b010, 200));
    tick();
    in_valid = 1'b0; wr_en = 1'b0;
    drain();
    writeVar(11'd9, 1'b0);

    // write to var 9 one edge after acceptance: live forward in S1
    presentClause(11'd5, 11'd9, 11'd12, 3'b000, 210);
    #1;
    checkOutput("fwd_next_in_ready", 64'(in_ready), 64'd1);
    expQ.push_back(mkExp(1'b0, 2'd1, 3'b010, 3'b010, 210));
    tick();
    in_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 11'd9; wr_data = 1'b1;
    tick();
    wr_en = 1'b0;
    drain();

    // three clauses streamed while the consumer stalls for five cycles
    streamV[0] = '{11'd20, 11'd21, 11'd22, 3'b000, 300, mkExp(1'b0, 2'd2, 3'b000, 3'b101, 300)};
    streamV[1] = '{11'd21, 11'd21, 11'd5, 3'b000, 310, mkExp(1'b1, 2'd0, 3'b000, 3'b000, 310)};
    streamV[2] = '{11'd22, 11'd5, 11'd20, 3'b010, 320, mkExp(1'b0, 2'd3, 3'b000, 3'b101, 320)};
    k = 0;
    cyc = 0;
    while (k < 3 && cyc < 40) begin
      out_ready = (cyc >= 5);
      presentClause(streamV[k].a0, streamV[k].a1, streamV[k].a2, streamV[k].neg, streamV[k].ib);
      #1;
      if (cyc == 4) checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      accepted = in_ready;
      if (accepted) expQ.push_back(streamV[k].e);
      tick();
      if (accepted) k++;
      cyc++;
    end
    checkOutput("stream_accepted", 64'(k), 64'd3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // saturating unsat counter with a 2-bit width
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checkOutput("cnt_cleared", 64'(unsat_cnt), 64'd0);
    for (int r = 0; r < 4; r++) begin
      applyStimulus(11'd21, 11'd21, 11'd5, 3'b000, 400 + r * 10,
                    mkExp(1'b1, 2'd0, 3'b000, 3'b000, 400 + r * 10));
      drain();
      case (r)
        0: checkOutput("cnt_step1", 64'(unsat_cnt), 64'd1);
        1: checkOutput("cnt_step2", 64'(unsat_cnt), 64'd2);
        2: checkOutput("cnt_step3", 64'(unsat_cnt), 64'd3);
        default: checkOutput("cnt_sat", 64'(unsat_cnt), 64'd3);
      endcase
    end
    applyStimulus(11'd21, 11'd21, 11'd5, 3'b000, 450, mkExp(1'b1, 2'd0, 3'b000, 3'b000, 450));
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("clr_wait_valid", 64'(out_valid), 64'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checkOutput("clr_wins", 64'(unsat_cnt), 64'd0);
    drain();

    // reset with two clauses in flight
    applyStimulus(11'd21, 11'd21, 11'd5, 3'b000, 500, mkExp(1'b1, 2'd0, 3'b000, 3'b000, 500));
    drain();
    checkOutput("pre_rst_cnt", 64'(unsat_cnt), 64'd1);
    presentClause(11'd21, 11'd21, 11'd5, 3'b000, 510);
    tick();
    presentClause(11'd20, 11'd21, 11'd22, 3'b000, 520);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_unsat_cnt", 64'(unsat_cnt), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("no_stale", 64'(out_valid), 64'd0);
    end
    applyStimulus(11'd20, 11'd21, 11'd22, 3'b111, 530, mkExp(1'b0, 2'd1, 3'b010, 3'b101, 530));
    drain();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
